// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}; everything here is active-high.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t s;
    case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-high segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg7_mux_driver.sv
// Multiplexed N-digit 7-segment driver: scan counters, frame-synchronous double
// buffering, blank/blink/leading-zero visibility, PWM brightness, registered pins.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 6,
  parameter int CLK_HZ         = 50_000_000,
  parameter int DIGIT_HZ       = 1000,
  parameter int BLINK_DIV      = 25_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  load,
  input  logic                  lz_suppress,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   dig_enable,
  output logic                  frame_start
);

  localparam int SLOT = CLK_HZ / DIGIT_HZ;
  localparam int SUB  = SLOT / 16;
  localparam int SW   = $clog2(SLOT);
  localparam int DW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int VW   = 4 * N_DIGITS;

  localparam logic [6:0]          SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [N_DIGITS-1:0] EN_IDLE  = DIG_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

  // Sixteen cycles is the shortest slot that still gives every brightness step a cycle.
  if ((SLOT % 16) != 0 || SLOT < 16) begin : g_bad_slot
    $error("seg7_mux_driver: CLK_HZ/DIGIT_HZ must be a multiple of 16");
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("seg7_mux_driver: N_DIGITS must be 1..8");
  end

  logic [SW-1:0]       slot_q, slot_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [VW-1:0]       pend_value_q, pend_value_d, disp_value_q, disp_value_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0] pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic [N_DIGITS-1:0] pend_blink_q, pend_blink_d, disp_blink_q, disp_blink_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                frame_start_q, frame_start_d;

  logic                slot_wrap, dig_last, boundary;
  logic [3:0]          cur_hex;
  logic                cur_dp, cur_blank, cur_blink, upper_nonzero;
  logic                lz_hide, visible, pwm_on, en_on;
  logic [SW-1:0]       pwm_idx;
  logic [6:0]          dec_seg, seg_raw;
  logic [N_DIGITS-1:0] dig_onehot;

  seg7_decode u_decode (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  always_comb begin
    slot_wrap = (slot_q == SW'(SLOT - 1));
    dig_last  = (dig_q == DW'(N_DIGITS - 1));
    boundary  = slot_wrap && dig_last;

    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    dig_d  = dig_q;
    if (slot_wrap) begin
      dig_d = dig_last ? '0 : dig_q + 1'b1;
    end

    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // A load landing on the frame boundary bypasses the pending stage entirely.
  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_blink_d = pend_blink_q;
    pending_d    = pending_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    disp_blink_d = disp_blink_q;
    if (load && !boundary) begin
      pend_value_d = value;
      pend_dp_d    = dp_mask;
      pend_blank_d = blank_mask;
      pend_blink_d = blink_mask;
      pending_d    = 1'b1;
    end else if (load && boundary) begin
      disp_value_d = value;
      disp_dp_d    = dp_mask;
      disp_blank_d = blank_mask;
      disp_blink_d = blink_mask;
      pending_d    = 1'b0;
    end else if (boundary && pending_q) begin
      disp_value_d = pend_value_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      disp_blink_d = pend_blink_q;
      pending_d    = 1'b0;
    end
  end

  always_comb begin
    cur_hex       = 4'h0;
    cur_dp        = 1'b0;
    cur_blank     = 1'b0;
    cur_blink     = 1'b0;
    upper_nonzero = 1'b0;
    dig_onehot    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (DW'(i) == dig_q) begin
        cur_hex   = disp_value_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = disp_blank_q[i];
        cur_blink = disp_blink_q[i];
      end
      if (DW'(i) >= dig_q && disp_value_q[4*i +: 4] != 4'h0) begin
        upper_nonzero = 1'b1;
      end
    end

    lz_hide = lz_suppress && (dig_q != '0) && !upper_nonzero;
    visible = !cur_blank && !(cur_blink && blink_phase_q) && !lz_hide;

    // Slot cycle 0 stays dark so the previous digit's segments cannot ghost.
    pwm_idx = slot_q / SW'(SUB);
    pwm_on  = (pwm_idx <= SW'(brightness));
    en_on   = visible && (slot_q != '0) && pwm_on;
    for (int i = 0; i < N_DIGITS; i++) begin
      dig_onehot[i] = en_on && (DW'(i) == dig_q);
    end

    seg_raw       = visible ? dec_seg : SEG_OFF;
    seg_d         = seg_raw ^ {7{SEG_ACTIVE_LOW}};
    dp_d          = (visible && cur_dp) ^ SEG_ACTIVE_LOW;
    dig_en_d      = dig_onehot ^ {N_DIGITS{DIG_ACTIVE_LOW}};
    frame_start_d = (slot_q == '0) && (dig_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q        <= '0;
      dig_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_blink_q  <= '0;
      pending_q     <= 1'b0;
      disp_value_q  <= '0;
      disp_dp_q     <= '0;
      disp_blank_q  <= '0;
      disp_blink_q  <= '0;
      seg_q         <= SEG_IDLE;
      dp_q          <= SEG_ACTIVE_LOW;
      dig_en_q      <= EN_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      dig_q         <= dig_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_blink_q  <= pend_blink_d;
      pending_q     <= pending_d;
      disp_value_q  <= disp_value_d;
      disp_dp_q     <= disp_dp_d;
      disp_blank_q  <= disp_blank_d;
      disp_blink_q  <= disp_blink_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign dig_enable  = dig_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed plus randomized bench for seg7_mux_driver (4 digits, 16-cycle slots,
// active-low pins) checked every cycle against a time-indexed display model.
module tb_seg7_mux_driver;

  localparam int N    = 4;
  localparam int SLOT = 16;
  localparam int BDIV = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  value = '0;
  logic [3:0]   dp_mask = '0, blank_mask = '0, blink_mask = '0;
  logic         load = 1'b0;
  logic         lz_suppress = 1'b0;
  logic [3:0]   brightness = 4'd15;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   dig_enable;
  logic         frame_start;

  seg7_mux_driver #(
    .N_DIGITS(N), .CLK_HZ(1600), .DIGIT_HZ(100), .BLINK_DIV(BDIV),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .load(load),
    .lz_suppress(lz_suppress), .brightness(brightness), .seg(seg), .dp(dp),
    .dig_enable(dig_enable), .frame_start(frame_start)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // active-high segment table {g,f,e,d,c,b,a}
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  int t = 0;
  bit valid = 1'b0;
  int prev_slot = -1, prev_dig = -1;
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_dp = '0, m_bk = '0, m_bl = '0, p_dp = '0, p_bk = '0, p_bl = '0;
  bit pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict pins from the model's current time index, advance, compare.
  task automatic tick();
    int slot, dig;
    bit ph, vis, en, bnd;
    logic [3:0] h;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    logic [3:0] e_en;
    slot = t % SLOT;
    dig  = (t / SLOT) % N;
    ph   = ((t / BDIV) % 2) == 1;
    h    = 4'((m_val >> (4 * dig)) & 16'hF);
    vis  = !m_bk[dig] && !(m_bl[dig] && ph) &&
           !(lz_suppress && dig != 0 && (m_val >> (4 * dig)) == 16'h0);
    en   = vis && slot != 0 && (slot / (SLOT / 16)) <= int'(brightness);
    if (reset) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_en = 4'hF; e_fs = 1'b0;
    end else begin
      e_seg = vis ? ~seg_tab[h] : 7'h7F;
      e_dp  = !(vis && m_dp[dig]);
      e_en  = en ? ~(4'b1 << dig) : 4'hF;
      e_fs  = (slot == 0 && dig == 0);
    end
    @(posedge clk);
    if (reset) begin
      t = 0; valid = 1'b1; pending = 1'b0;
      m_val = '0; m_dp = '0; m_bk = '0; m_bl = '0;
      p_val = '0; p_dp = '0; p_bk = '0; p_bl = '0;
      prev_slot = -1; prev_dig = -1;
    end else begin
      bnd = (slot == SLOT - 1) && (dig == N - 1);
      if (load && bnd) begin
        m_val = value; m_dp = dp_mask; m_bk = blank_mask; m_bl = blink_mask;
        pending = 1'b0;
      end else if (load) begin
        p_val = value; p_dp = dp_mask; p_bk = blank_mask; p_bl = blink_mask;
        pending = 1'b1;
      end else if (bnd && pending) begin
        m_val = p_val; m_dp = p_dp; m_bk = p_bk; m_bl = p_bl;
        pending = 1'b0;
      end
      t++;
      prev_slot = slot; prev_dig = dig;
    end
    #1;
    if (valid) begin
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("dig_enable", dig_enable, e_en);
      chk("frame_start", frame_start, e_fs);
    end
  endtask

  // driver tasks
  task automatic do_load(input logic [15:0] v, input logic [3:0] dpm, bkm, blm);
    value = v; dp_mask = dpm; blank_mask = bkm; blink_mask = blm;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_pos(input int d, input int s);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(prev_dig == d && prev_slot == s) && n < 300);
    chk("wait_pos", {31'b0, (prev_dig == d && prev_slot == s)}, 32'd1);
  endtask

  task automatic expect_digit(input int d, input logic [6:0] seg_e, input bit on_e);
    logic [3:0] en_e;
    en_e = on_e ? ~(4'b1 << d) : 4'hF;
    wait_pos(d, 1);
    chk($sformatf("digit%0d_seg", d), seg, seg_e);
    chk($sformatf("digit%0d_en", d), dig_enable, en_e);
  endtask

  task automatic count_on(input int d, input int exp_on);
    int cnt = 0;
    wait_pos(d, 0);
    for (int k = 0; k < SLOT - 1; k++) begin
      tick();
      if (dig_enable[d] === 1'b0) cnt++;
    end
    chk($sformatf("on_cycles_b%0d", exp_on), cnt, exp_on);
  endtask

  initial begin
    // reset held three cycles
    for (int k = 0; k < 3; k++) tick();
    chk("rst_en", dig_enable, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_fs", frame_start, 1'b0);
    reset = 1'b0;

    // first load, mid-frame
    for (int k = 0; k < 20; k++) tick();
    do_load(16'h12A0, 4'h0, 4'h0, 4'h0);
    wait_pos(0, 0);
    expect_digit(0, 7'h40, 1'b1);
    expect_digit(1, 7'h08, 1'b1);
    expect_digit(2, 7'h24, 1'b1);
    expect_digit(3, 7'h79, 1'b1);

    // leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0030, 4'h0, 4'h0, 4'h0);
    wait_pos(0, 0);
    expect_digit(0, 7'h40, 1'b1);
    expect_digit(1, 7'h30, 1'b1);
    expect_digit(2, 7'h7F, 1'b0);
    expect_digit(3, 7'h7F, 1'b0);
    do_load(16'h0000, 4'h0, 4'h0, 4'h0);
    wait_pos(0, 0);
    expect_digit(0, 7'h40, 1'b1);
    expect_digit(1, 7'h7F, 1'b0);
    expect_digit(2, 7'h7F, 1'b0);
    expect_digit(3, 7'h7F, 1'b0);
    lz_suppress = 1'b0;

    // brightness
    do_load(16'h12A0, 4'h0, 4'h0, 4'h0);
    brightness = 4'd3;
    count_on(2, 3);
    brightness = 4'd15;
    count_on(1, 15);

    // blink and decimal point
    do_load(16'h12A0, 4'b0001, 4'h0, 4'b0010);
    for (int k = 0; k < 256; k++) tick();
    begin
      int dp_lo = 0;
      wait_pos(0, 0);
      if (dp === 1'b0) dp_lo++;
      for (int k = 0; k < SLOT * N - 1; k++) begin
        tick();
        if (dp === 1'b0) dp_lo++;
      end
      chk("dp_low_cycles", dp_lo, SLOT);
    end

    // two loads in one frame: last one wins
    wait_pos(0, 5);
    do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) tick();
    do_load(16'h2222, 4'h0, 4'h0, 4'h0);
    wait_pos(0, 0);
    expect_digit(0, 7'h24, 1'b1);
    expect_digit(3, 7'h24, 1'b1);

    // load exactly on the frame boundary
    wait_pos(3, 14);
    do_load(16'h3333, 4'h0, 4'h0, 4'h0);
    expect_digit(0, 7'h30, 1'b1);

    // randomized phase
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 24) == 0) begin
        do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)),
                4'($urandom));
      end else begin
        tick();
      end
    end
    brightness = 4'd15; lz_suppress = 1'b0;
    do_load(16'h4567, 4'h0, 4'h0, 4'h0);
    wait_pos(1, 0);

    // reset mid-operation, with a competing load
    wait_pos(2, 5);
    reset = 1'b1;
    value = 16'hFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    chk("midrst_en", dig_enable, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_fs", frame_start, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_fs", frame_start, 1'b1);
    expect_digit(0, 7'h40, 1'b1);
    expect_digit(3, 7'h40, 1'b1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
